ysyx_25020037_ifu: RTL and testbench
====================================

YSYX_25020037_IFU -- requirements
Module: ysyx_25020037_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h3000_0000, address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port npc_valid, input, 1, next-PC pulse from writeback/commit.
REQ-005 SHALL have port npc, input, 32, next fetch address, qualified by npc_valid.
REQ-006 SHALL have ports ifu_arvalid (output, 1), ifu_araddr (output, 32) and ifu_arready (input, 1), forming the bus read-address channel.
REQ-007 SHALL have ports ifu_rready (output, 1), bus_rvalid (input, 1), bus_rdata (input, 32) and bus_rresp (input, 2), forming the bus read-data channel.
REQ-008 SHALL have ports ifu_rvalid (output, 1), inst (output, 32), pc (output, 32) and idu_ready (input, 1), forming the handshake to the decode stage.
REQ-009 SHALL have port ifu_fault, output, 1, sideband valid with ifu_rvalid; high when bus_rresp is nonzero.
REQ-010 SHALL have ports perf_fetch_cnt (output, 32) and perf_wait_cnt (output, 32), performance counters.

Function
REQ-011 SHALL implement states BOOT, AR, R, DELIVER, WAIT_NPC.
REQ-012 BOOT SHALL go to AR on the first clock after reset release, loading fetch_pc=RESET_PC.
REQ-013 AR SHALL hold ifu_arvalid=1, ifu_araddr=fetch_pc stable until ifu_arvalid&ifu_arready, then go to R.
REQ-014 R SHALL hold ifu_rready=1; on bus_rvalid&ifu_rready it SHALL register inst=bus_rdata, pc=fetch_pc, ifu_fault=(bus_rresp!=0), then go to DELIVER.
REQ-015 DELIVER SHALL hold ifu_rvalid=1 with inst, pc and ifu_fault stable until ifu_rvalid&idu_ready; on that cycle ifu_rvalid SHALL drop next cycle.
REQ-016 On leaving DELIVER, the state SHALL go to AR with fetch_pc=pending_npc if a pending NPC is held, else to WAIT_NPC.
REQ-017 WAIT_NPC SHALL load fetch_pc=npc and go to AR on npc_valid.
REQ-018 npc_valid arriving in AR, R or DELIVER SHALL be latched into a one-entry pending register; a later pulse overwrites it, the last value wins.
REQ-019 npc_valid coinciding with the DELIVER handshake SHALL use the incoming npc directly and bypass the pending register.
REQ-020 npc_valid in BOOT SHALL be ignored.
REQ-021 ifu_araddr[1:0] SHALL be driven 2'b00 and fetch_pc[1:0] ignored.
REQ-022 At most one fetch SHALL be outstanding; minimum latency SHALL be AR->DELIVER 2 cycles with arready and rvalid immediately high.
REQ-023 ifu_arvalid, once asserted, SHALL NOT be deasserted before arready.

Reset
REQ-024 rst_n low SHALL asynchronously force: state BOOT; ifu_arvalid, ifu_rready, ifu_rvalid and ifu_fault 0; ifu_araddr, inst, pc and the pending register 0; perf counters 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it; no data from the abandoned fetch is delivered after reset release.

Configuration
REQ-026 With macro YSYX_25020037_IFU_PERF_EN defined: perf_fetch_cnt SHALL increment on each ifu_rvalid&idu_ready handshake, and perf_wait_cnt SHALL increment each cycle in AR or R; both wrap modulo 2^32.
REQ-027 Without YSYX_25020037_IFU_PERF_EN: both counter outputs SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-028 Reset release, arready=1, rvalid=1 next cycle, rdata=32'h0000_0013: SHALL show araddr=32'h3000_0000 at cycle 1, then ifu_rvalid=1, inst=32'h13, pc=32'h3000_0000.
REQ-029 DELIVER with idu_ready held 0 for 5 cycles: SHALL keep ifu_rvalid, inst and pc unchanged; handshake on cycle 6 SHALL drop ifu_rvalid next cycle.
REQ-030 npc_valid with npc=32'h3000_0010 during R, then a second pulse with npc=32'h3000_0020 during DELIVER: the next ifu_araddr SHALL be 32'h3000_0020 with no WAIT_NPC cycle.
REQ-031 rresp=2'b10 on fetch: SHALL give ifu_fault=1 alongside ifu_rvalid; the next clean fetch SHALL give ifu_fault=0.
REQ-032 rst_n pulsed low while in R with a late rvalid: SHALL give ifu_rvalid=0 and a fresh fetch at 32'h3000_0000.
REQ-033 PERF_EN on, 3 fetches with arready delayed 2 cycles each: SHALL give perf_fetch_cnt=3 and perf_wait_cnt=12; PERF_EN off: both SHALL be 0.

Source files
------------

// File: rtl/ysyx_25020037_ifu.sv
// rtl/ysyx_25020037_ifu.sv - instruction fetch unit with single outstanding bus read
// Optional performance counters are built only when YSYX_25020037_IFU_PERF_EN is defined.
module ysyx_25020037_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        ifu_arvalid,
    output logic [31:0] ifu_araddr,
    input  logic        ifu_arready,
    output logic        ifu_rready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  bus_rresp,
    output logic        ifu_rvalid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        idu_ready,
    output logic        ifu_fault,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_AR,
        S_R,
        S_DELIVER,
        S_WAIT_NPC
    } state_e;

    state_e      state_q, state_d;
    logic [31:2] fetch_pc_q, fetch_pc_d;
    logic [31:2] pend_npc_q, pend_npc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] inst_q, inst_d;
    logic [31:2] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic        deliver_hs;

    // Fetch addresses are word aligned, so the two low npc bits carry no information.
    logic unused_npc_lsbs;
    assign unused_npc_lsbs = ^npc[1:0];

    assign deliver_hs = (state_q == S_DELIVER) && idu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= '0;
            pend_npc_q <= '0;
            pend_vld_q <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_npc_q <= pend_npc_d;
            pend_vld_q <= pend_vld_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_npc_d = pend_npc_q;
        pend_vld_d = pend_vld_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        fault_d    = fault_q;

        case (state_q)
            S_BOOT: begin
                state_d    = S_AR;
                fetch_pc_d = RESET_PC[31:2];
            end
            S_AR: begin
                if (ifu_arready) begin
                    state_d = S_R;
                end
                if (npc_valid) begin
                    pend_vld_d = 1'b1;
                    pend_npc_d = npc[31:2];
                end
            end
            S_R: begin
                if (bus_rvalid) begin
                    state_d = S_DELIVER;
                    inst_d  = bus_rdata;
                    pc_d    = fetch_pc_q;
                    fault_d = (bus_rresp != 2'b00);
                end
                if (npc_valid) begin
                    pend_vld_d = 1'b1;
                    pend_npc_d = npc[31:2];
                end
            end
            S_DELIVER: begin
                if (deliver_hs) begin
                    // A redirect arriving on the handshake cycle is newer than anything held.
                    pend_vld_d = 1'b0;
                    if (npc_valid) begin
                        state_d    = S_AR;
                        fetch_pc_d = npc[31:2];
                    end else if (pend_vld_q) begin
                        state_d    = S_AR;
                        fetch_pc_d = pend_npc_q;
                    end else begin
                        state_d = S_WAIT_NPC;
                    end
                end else if (npc_valid) begin
                    pend_vld_d = 1'b1;
                    pend_npc_d = npc[31:2];
                end
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    state_d    = S_AR;
                    fetch_pc_d = npc[31:2];
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign ifu_arvalid = (state_q == S_AR);
    assign ifu_araddr  = {fetch_pc_q, 2'b00};
    assign ifu_rready  = (state_q == S_R);
    assign ifu_rvalid  = (state_q == S_DELIVER);
    assign inst        = inst_q;
    assign pc          = {pc_q, 2'b00};
    assign ifu_fault   = fault_q;

`ifdef YSYX_25020037_IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_wait_d  = perf_wait_q;
        if (deliver_hs) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if ((state_q == S_AR) || (state_q == S_R)) begin
            perf_wait_d = perf_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_wait_q  <= perf_wait_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_wait_cnt  = perf_wait_q;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// tb/tb_ysyx_25020037_ifu.sv - directed self-checking bench for ysyx_25020037_ifu
module tb_ysyx_25020037_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        npc_valid;
    logic [31:0] npc;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_rresp;
    logic        ifu_rvalid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        idu_ready;
    logic        ifu_fault;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25020037_ifu #(.RESET_PC(32'h3000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .npc_valid     (npc_valid),
        .npc           (npc),
        .ifu_arvalid   (ifu_arvalid),
        .ifu_araddr    (ifu_araddr),
        .ifu_arready   (ifu_arready),
        .ifu_rready    (ifu_rready),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_rresp     (bus_rresp),
        .ifu_rvalid    (ifu_rvalid),
        .inst          (inst),
        .pc            (pc),
        .idu_ready     (idu_ready),
        .ifu_fault     (ifu_fault),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt (perf_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        npc_valid   = 1'b0;
        npc         = '0;
        ifu_arready = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;
        bus_rresp   = 2'b00;
        idu_ready   = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_arvalid", ifu_arvalid, 0);
        chk("rst_rready", ifu_rready, 0);
        chk("rst_rvalid", ifu_rvalid, 0);
        chk("rst_fault", ifu_fault, 0);
        chk("rst_araddr", ifu_araddr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", pc, 0);
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_wait", perf_wait_cnt, 0);

        // first fetch with a zero-wait bus
        ifu_arready = 1'b1;
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'h0000_0013;
        rst_n       = 1'b1;
        step();
        chk("c1_arvalid", ifu_arvalid, 1);
        chk("c1_araddr", ifu_araddr, 32'h3000_0000);
        chk("c1_rready", ifu_rready, 0);
        step();
        chk("c2_rready", ifu_rready, 1);
        chk("c2_arvalid", ifu_arvalid, 0);
        step();
        chk("c3_rvalid", ifu_rvalid, 1);
        chk("c3_inst", inst, 32'h0000_0013);
        chk("c3_pc", pc, 32'h3000_0000);
        chk("c3_fault", ifu_fault, 0);

        // decode stalls for five cycles
        bus_rdata = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rvalid", ifu_rvalid, 1);
            chk("stall_inst", inst, 32'h0000_0013);
            chk("stall_pc", pc, 32'h3000_0000);
        end
        idu_ready = 1'b1;
        step();
        chk("hs_rvalid_drop", ifu_rvalid, 0);
        chk("wait_arvalid", ifu_arvalid, 0);
        idu_ready = 1'b0;
        step();
        chk("wait_hold_arvalid", ifu_arvalid, 0);

        // misaligned npc, arready held off
        npc_valid   = 1'b1;
        npc         = 32'h3000_0007;
        ifu_arready = 1'b0;
        step();
        npc_valid = 1'b0;
        chk("ar_arvalid", ifu_arvalid, 1);
        chk("ar_araddr_align", ifu_araddr, 32'h3000_0004);
        step();
        chk("ar_hold_arvalid", ifu_arvalid, 1);
        chk("ar_hold_araddr", ifu_araddr, 32'h3000_0004);

        // redirect during R, overwritten during DELIVER; faulting response
        ifu_arready = 1'b1;
        bus_rvalid  = 1'b0;
        step();
        chk("r_rready", ifu_rready, 1);
        npc_valid = 1'b1;
        npc       = 32'h3000_0010;
        step();
        npc_valid = 1'b0;
        chk("r_late_rready", ifu_rready, 1);
        chk("r_late_rvalid", ifu_rvalid, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0010_0093;
        bus_rresp  = 2'b10;
        step();
        chk("flt_rvalid", ifu_rvalid, 1);
        chk("flt_fault", ifu_fault, 1);
        chk("flt_inst", inst, 32'h0010_0093);
        chk("flt_pc", pc, 32'h3000_0004);
        npc_valid = 1'b1;
        npc       = 32'h3000_0020;
        step();
        npc_valid = 1'b0;
        chk("ovr_rvalid", ifu_rvalid, 1);
        idu_ready = 1'b1;
        step();
        chk("pend_rvalid", ifu_rvalid, 0);
        chk("pend_arvalid", ifu_arvalid, 1);
        chk("pend_araddr", ifu_araddr, 32'h3000_0020);

        // clean fetch; redirect on the handshake beats the held one
        bus_rresp = 2'b00;
        bus_rdata = 32'h0020_0113;
        npc_valid = 1'b1;
        npc       = 32'h3000_0030;
        step();
        npc_valid = 1'b0;
        step();
        chk("cln_rvalid", ifu_rvalid, 1);
        chk("cln_fault", ifu_fault, 0);
        chk("cln_pc", pc, 32'h3000_0020);
        chk("cln_inst", inst, 32'h0020_0113);
        npc_valid = 1'b1;
        npc       = 32'h3000_0040;
        step();
        npc_valid = 1'b0;
        chk("byp_arvalid", ifu_arvalid, 1);
        chk("byp_araddr", ifu_araddr, 32'h3000_0040);
        step();
        step();
        chk("byp_pc", pc, 32'h3000_0040);
        step();
        chk("byp_clear_arvalid", ifu_arvalid, 0);
        chk("byp_clear_rvalid", ifu_rvalid, 0);

        // reset while waiting for read data
        bus_rvalid = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h3000_0100;
        step();
        npc_valid = 1'b0;
        step();
        chk("mid_rready", ifu_rready, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rready", ifu_rready, 0);
        chk("async_arvalid", ifu_arvalid, 0);
        chk("async_araddr", ifu_araddr, 0);
        chk("async_pc", pc, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hbad0_bad0;
        @(negedge clk);
        chk("inrst_rvalid", ifu_rvalid, 0);
        npc_valid = 1'b1;
        npc       = 32'h3000_0200;
        bus_rdata = 32'h0000_0073;
        rst_n     = 1'b1;
        step();
        npc_valid = 1'b0;
        chk("rel_araddr", ifu_araddr, 32'h3000_0000);
        chk("rel_rvalid", ifu_rvalid, 0);
        step();
        step();
        chk("rel_inst", inst, 32'h0000_0073);
        chk("rel_pc", pc, 32'h3000_0000);
        step();
        chk("boot_npc_ignored", ifu_arvalid, 0);

        // three fetches with arready delayed two cycles each
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                npc_valid = 1'b1;
                npc       = 32'h3000_0000 + 32'(4 * k);
                step();
                npc_valid = 1'b0;
            end
            ifu_arready = 1'b0;
            step();
            step();
            ifu_arready = 1'b1;
            step();
            step();
            chk("perf_rvalid", ifu_rvalid, 1);
            step();
        end
`ifdef YSYX_25020037_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 3);
        chk("perf_wait", perf_wait_cnt, 12);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 0);
        chk("perf_wait_off", perf_wait_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
